// File: rtl/game_ctrl_gen2_if.sv
// Control bundle between the sequence-memory game controller and its datapath/front panel.
// The driver side supplies the button and datapath status; the controller side returns enables and game state.
interface game_ctrl_gen2_if #(
    parameter int ROUNDS         = 16,
    parameter int LIVES          = 3,
    parameter int TIMEOUT_CYCLES = 250000000
);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          enter;
    logic          end_FPGA;
    logic          end_User;
    logic          match;
    logic          R1;
    logic          R2;
    logic          E1;
    logic          E2;
    logic          E3;
    logic          E4;
    logic          SEL;
    logic [RW-1:0] round;
    logic [LW-1:0] lives_left;
    logic [TW-1:0] timer;
    logic          win;
    logic          lose;
    logic [2:0]    state_dbg;

    modport master (
        output enter, end_FPGA, end_User, match,
        input  R1, R2, E1, E2, E3, E4, SEL, round, lives_left, timer, win, lose, state_dbg
    );

    modport slave (
        input  enter, end_FPGA, end_User, match,
        output R1, R2, E1, E2, E3, E4, SEL, round, lives_left, timer, win, lose, state_dbg
    );
endinterface

// File: rtl/game_ctrl_gen2.sv
// Second-generation sequence-memory game controller: owns round count, entry timeout,
// retry lives and the win/lose decision; all control outputs are registered Moore decodes.
module game_ctrl_gen2 #(
    parameter int ROUNDS         = 16,
    parameter int LIVES          = 3,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input logic             CLOCK,
    input logic             reset,
    game_ctrl_gen2_if.slave bus
);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [LW-1:0] FULL_LIVES = LW'(LIVES);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHOW   = 3'd2,
        INPUT  = 3'd3,
        CHECK  = 3'd4,
        NEXT   = 3'd5,
        MISS   = 3'd6,
        RESULT = 3'd7
    } state_t;

    state_t        state, nxt;
    logic          enter_q, press;
    logic          won, won_n;
    logic [RW-1:0] round_q;
    logic [LW-1:0] lives_q;
    logic [TW-1:0] timer_q;
    logic [6:0]    ctl_q;
    logic          win_q, lose_q;

    // {R1, R2, E1, E2, E3, E4, SEL}
    function automatic logic [6:0] decode(state_t s);
        case (s)
            IDLE:    decode = 7'b1100000;
            SETUP:   decode = 7'b0010000;
            SHOW:    decode = 7'b0101000;
            INPUT:   decode = 7'b0000100;
            RESULT:  decode = 7'b0000011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign press = bus.enter & ~enter_q;

    always_comb begin
        nxt   = state;
        won_n = won;
        case (state)
            IDLE: begin
                won_n = 1'b0;
                if (press) nxt = SETUP;
            end
            SETUP: nxt = SHOW;
            SHOW:  if (bus.end_FPGA) nxt = INPUT;
            INPUT: begin
                // a late entry on the final cycle still counts as on time
                if (bus.end_User)            nxt = CHECK;
                else if (timer_q == TIMER_MAX) nxt = MISS;
            end
            CHECK: begin
                won_n = bus.match && (round_q == LAST_ROUND);
                if (!bus.match)                  nxt = MISS;
                else if (round_q == LAST_ROUND)  nxt = RESULT;
                else                             nxt = NEXT;
            end
            NEXT: nxt = SHOW;
            MISS: begin
                won_n = 1'b0;
                nxt   = (lives_q == LW'(1)) ? RESULT : SHOW;
            end
            RESULT: if (press) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state   <= IDLE;
            enter_q <= 1'b1;
            won     <= 1'b0;
            round_q <= '0;
            lives_q <= FULL_LIVES;
            timer_q <= '0;
            ctl_q   <= decode(IDLE);
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state   <= nxt;
            enter_q <= bus.enter;
            won     <= won_n;
            ctl_q   <= decode(nxt);
            win_q   <= (nxt == RESULT) && won_n;
            lose_q  <= (nxt == RESULT) && !won_n;
            timer_q <= (state == INPUT && nxt == INPUT) ? timer_q + TW'(1) : '0;
            // counters are already fresh on the first IDLE cycle after a result
            if (nxt == IDLE) begin
                round_q <= '0;
                lives_q <= FULL_LIVES;
            end else if (state == NEXT) begin
                round_q <= round_q + RW'(1);
            end else if (state == MISS) begin
                lives_q <= lives_q - LW'(1);
            end
        end
    end

    assign {bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL} = ctl_q;
    assign bus.round      = round_q;
    assign bus.lives_left = lives_q;
    assign bus.timer      = timer_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_game_ctrl_gen2.sv
// Randomised bench for game_ctrl_gen2: a game-level model (round, lives, outcome per attempt)
// predicts state, outputs and counters after every cycle of each attempt.
module tb_game_ctrl_gen2;
    localparam int ROUNDS = 4;
    localparam int LIVES  = 2;
    localparam int TMO    = 10;

    localparam int S_IDLE = 0, S_SETUP = 1, S_SHOW = 2, S_INPUT = 3;
    localparam int S_CHECK = 4, S_NEXT = 5, S_MISS = 6, S_RESULT = 7;

    localparam int K_OK = 0, K_BAD = 1, K_TMO = 2;

    logic CLOCK = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    int   m_round, m_lives;
    bit   m_done;

    game_ctrl_gen2_if #(.ROUNDS(ROUNDS), .LIVES(LIVES), .TIMEOUT_CYCLES(TMO)) bus();

    game_ctrl_gen2 #(.ROUNDS(ROUNDS), .LIVES(LIVES), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    // {R1, R2, E1, E2, E3, E4, SEL} required in each state
    function automatic logic [6:0] spec_outs(int s);
        case (s)
            S_IDLE:   return 7'b1100000;
            S_SETUP:  return 7'b0010000;
            S_SHOW:   return 7'b0101000;
            S_INPUT:  return 7'b0000100;
            S_RESULT: return 7'b0000011;
            default:  return 7'b0000000;
        endcase
    endfunction

    function automatic logic [19:0] expv(int s, bit w, bit l, int r, int lv, int t);
        return {3'(s), spec_outs(s), w, l, 2'(r), 2'(lv), 4'(t)};
    endfunction

    function automatic logic [19:0] obsv();
        return {bus.state_dbg, bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL,
                bus.win, bus.lose, bus.round, bus.lives_left, bus.timer};
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_game();
        bus.enter = 1'b0;
        tick();
        bus.enter = 1'b1;
        tick();
        vecs++;
        if (obsv() !== expv(S_SETUP, 0, 0, 0, LIVES, 0)) begin
            errs++;
            $display("FAIL start_setup: got %h want %h", obsv(), expv(S_SETUP, 0, 0, 0, LIVES, 0));
        end
        bus.enter = 1'b0;
        tick();
        vecs++;
        if (obsv() !== expv(S_SHOW, 0, 0, 0, LIVES, 0)) begin
            errs++;
            $display("FAIL start_show: got %h want %h", obsv(), expv(S_SHOW, 0, 0, 0, LIVES, 0));
        end
        m_round = 0;
        m_lives = LIVES;
        m_done  = 1'b0;
    endtask

    task automatic end_game();
        bus.enter = 1'b0;
        tick();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        vecs++;
        if (obsv() !== expv(S_IDLE, 0, 0, 0, LIVES, 0)) begin
            errs++;
            $display("FAIL result_to_idle: got %h want %h", obsv(), expv(S_IDLE, 0, 0, 0, LIVES, 0));
        end
    endtask

    // One attempt at the current round, starting in SHOW; ends in SHOW or RESULT.
    task automatic attempt(input int kind, input int fd, input int ud);
        bit win_now;
        for (int i = 0; i < fd; i++) begin
            bus.end_User = 1'($urandom_range(0, 1));
            bus.match    = 1'($urandom_range(0, 1));
            tick();
            vecs++;
            if (obsv() !== expv(S_SHOW, 0, 0, m_round, m_lives, 0)) begin
                errs++;
                $display("FAIL show_hold: got %h want %h", obsv(), expv(S_SHOW, 0, 0, m_round, m_lives, 0));
            end
        end
        bus.end_User = 1'b0;
        bus.end_FPGA = 1'b1;
        tick();
        bus.end_FPGA = 1'b0;
        vecs++;
        if (obsv() !== expv(S_INPUT, 0, 0, m_round, m_lives, 0)) begin
            errs++;
            $display("FAIL input_entry: got %h want %h", obsv(), expv(S_INPUT, 0, 0, m_round, m_lives, 0));
        end
        for (int i = 1; i <= ((kind == K_TMO) ? TMO - 1 : ud); i++) begin
            bus.end_FPGA = 1'($urandom_range(0, 1));
            tick();
            vecs++;
            if (obsv() !== expv(S_INPUT, 0, 0, m_round, m_lives, i)) begin
                errs++;
                $display("FAIL input_timer: got %h want %h", obsv(), expv(S_INPUT, 0, 0, m_round, m_lives, i));
            end
        end
        bus.end_FPGA = 1'b0;
        if (kind != K_TMO) begin
            bus.end_User = 1'b1;
            bus.match    = (kind == K_OK);
            tick();
            bus.end_User = 1'b0;
            vecs++;
            if (obsv() !== expv(S_CHECK, 0, 0, m_round, m_lives, 0)) begin
                errs++;
                $display("FAIL check_entry: got %h want %h", obsv(), expv(S_CHECK, 0, 0, m_round, m_lives, 0));
            end
        end
        tick();
        bus.match = 1'b0;
        if (kind == K_OK) begin
            win_now = (m_round == ROUNDS - 1);
            if (win_now) begin
                vecs++;
                if (obsv() !== expv(S_RESULT, 1, 0, m_round, m_lives, 0)) begin
                    errs++;
                    $display("FAIL result_win: got %h want %h", obsv(), expv(S_RESULT, 1, 0, m_round, m_lives, 0));
                end
                m_done = 1'b1;
            end else begin
                vecs++;
                if (obsv() !== expv(S_NEXT, 0, 0, m_round, m_lives, 0)) begin
                    errs++;
                    $display("FAIL next_state: got %h want %h", obsv(), expv(S_NEXT, 0, 0, m_round, m_lives, 0));
                end
                tick();
                m_round++;
                vecs++;
                if (obsv() !== expv(S_SHOW, 0, 0, m_round, m_lives, 0)) begin
                    errs++;
                    $display("FAIL round_advance: got %h want %h", obsv(), expv(S_SHOW, 0, 0, m_round, m_lives, 0));
                end
            end
        end else begin
            vecs++;
            if (obsv() !== expv(S_MISS, 0, 0, m_round, m_lives, 0)) begin
                errs++;
                $display("FAIL miss_state: got %h want %h", obsv(), expv(S_MISS, 0, 0, m_round, m_lives, 0));
            end
            tick();
            m_lives--;
            if (m_lives == 0) begin
                m_done = 1'b1;
                vecs++;
                if (obsv() !== expv(S_RESULT, 0, 1, m_round, 0, 0)) begin
                    errs++;
                    $display("FAIL result_lose: got %h want %h", obsv(), expv(S_RESULT, 0, 1, m_round, 0, 0));
                end
            end else begin
                vecs++;
                if (obsv() !== expv(S_SHOW, 0, 0, m_round, m_lives, 0)) begin
                    errs++;
                    $display("FAIL retry_show: got %h want %h", obsv(), expv(S_SHOW, 0, 0, m_round, m_lives, 0));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enter = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        vecs++;
        if (obsv() !== expv(S_IDLE, 0, 0, 0, LIVES, 0)) begin
            errs++;
            $display("FAIL reset_state: got %h want %h", obsv(), expv(S_IDLE, 0, 0, 0, LIVES, 0));
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (obsv() !== expv(S_IDLE, 0, 0, 0, LIVES, 0)) begin
                errs++;
                $display("FAIL held_enter_no_press: got %h want %h", obsv(), expv(S_IDLE, 0, 0, 0, LIVES, 0));
            end
        end
        start_game();
    endtask

    task automatic test_full_win();
        do_reset();
        start_game();
        for (int r = 0; r < ROUNDS; r++) attempt(K_OK, $urandom_range(0, 3), $urandom_range(0, TMO - 1));
        vecs++;
        if (!m_done) begin
            errs++;
            $display("FAIL full_win_done: got %0d want 1", m_done);
        end
        end_game();
    endtask

    task automatic test_timeout_and_lose();
        do_reset();
        start_game();
        attempt(K_TMO, 1, 0);
        attempt(K_OK, 0, TMO - 1);
        attempt(K_BAD, 2, 3);
        end_game();
    endtask

    task automatic test_random_games();
        int kind, n;
        for (int g = 0; g < 4; g++) begin
            do_reset();
            start_game();
            n = 0;
            while (!m_done && n < ROUNDS + LIVES + 2) begin
                kind = $urandom_range(0, 3);
                attempt((kind >= 2) ? K_OK : kind, $urandom_range(0, 4), $urandom_range(0, TMO - 1));
                n++;
            end
            vecs++;
            if (!m_done) begin
                errs++;
                $display("FAIL random_game_end: got %0d want 1", m_done);
            end
            end_game();
        end
    endtask

    task automatic test_reset_mid_game();
        do_reset();
        start_game();
        attempt(K_OK, 0, 2);
        attempt(K_OK, 1, 4);
        bus.end_FPGA = 1'b1;
        tick();
        bus.end_FPGA = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if (obsv() !== expv(S_IDLE, 0, 0, 0, LIVES, 0)) begin
            errs++;
            $display("FAIL mid_reset: got %h want %h", obsv(), expv(S_IDLE, 0, 0, 0, LIVES, 0));
        end
        for (int i = 0; i < 6; i++) begin
            bus.end_FPGA = 1'($urandom_range(0, 1));
            bus.end_User = 1'($urandom_range(0, 1));
            bus.match    = 1'($urandom_range(0, 1));
            tick();
            vecs++;
            if (obsv() !== expv(S_IDLE, 0, 0, 0, LIVES, 0)) begin
                errs++;
                $display("FAIL idle_ignores_inputs: got %h want %h", obsv(), expv(S_IDLE, 0, 0, 0, LIVES, 0));
            end
        end
        bus.end_FPGA = 1'b0;
        bus.end_User = 1'b0;
        bus.match    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.enter    = 1'b1;
        bus.end_FPGA = 1'b0;
        bus.end_User = 1'b0;
        bus.match    = 1'b0;
        test_reset();
        test_full_win();
        test_timeout_and_lose();
        test_random_games();
        test_reset_mid_game();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/game_ctrl_gen2.md
Name: game_ctrl_gen2

Overview:
- Parametrised second-generation control FSM for the sequence-memory game.
- Sequences the datapath through setup, FPGA display, user entry, compare and result phases.
- Internalises what the first-generation controller took as external inputs: the round count, the user-entry timeout, the retry lives and the win/lose decision.
- Drives the datapath register clears (R1/R2), the enables (E1..E4) and the display select (SEL).

Parameters:
- ROUNDS, 16, number of rounds needed to win (>=2); round counter width RW = max(1, clog2(ROUNDS)).
- LIVES, 3, mismatches/timeouts tolerated before losing (>=1); lives width LW = clog2(LIVES+1).
- TIMEOUT_CYCLES, 250000000, CLOCK cycles allowed in user entry (5 s at 50 MHz; >=2); timer width TW = clog2(TIMEOUT_CYCLES).

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enter  in  1  level-sensitive button, already synchronised; the block edge-detects it.
- end_FPGA  in  1  datapath has finished displaying the current sequence.
- end_User  in  1  user has entered the full sequence for the current round.
- match  in  1  user sequence equals reference; sampled only in CHECK.
- R1  out  1  clear all datapath registers.
- R2  out  1  clear user-entry registers.
- E1  out  1  load setup/seed registers.
- E2  out  1  FPGA sequence display enable.
- E3  out  1  user entry enable.
- E4  out  1  result display enable.
- SEL  out  1  display mux: 0 = game, 1 = result.
- round  out  RW  current round index, 0-based.
- lives_left  out  LW  remaining lives.
- timer  out  TW  user-entry cycle counter.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.
- state_dbg  out  3  current state encoding.

Behaviour:
- Encoding: IDLE=0, SETUP=1, SHOW=2, INPUT=3, CHECK=4, NEXT=5, MISS=6, RESULT=7. In RESULT, win/lose distinguish WIN from LOSE via a registered flag.
- press = enter & ~enter_q. enter_q is a register with reset value 1, so a button held through reset never produces a press.
- Reset (any state, mid-game included): next edge gives state=IDLE, round=0, lives_left=LIVES, timer=0, result flag=0. After that edge: R1=R2=1, all other outputs 0, state_dbg=0.
- All control outputs are Moore, decoded from state only. Outputs not listed for a state are 0.
- IDLE:
  - Outputs: R1=1, R2=1.
  - round=0, lives_left=LIVES.
  - press -> SETUP.
- SETUP:
  - Outputs: E1=1.
  - Exactly one cycle, then -> SHOW.
- SHOW:
  - Outputs: E2=1, R2=1.
  - end_FPGA -> INPUT; otherwise stay.
- INPUT:
  - Outputs: E3=1.
  - timer increments each cycle in INPUT. timer is 0 in every other state; it clears on exit.
  - end_User -> CHECK.
  - Else if timer==TIMEOUT_CYCLES-1 -> MISS.
  - end_User on the timeout cycle counts as on time: -> CHECK.
- CHECK (one cycle):
  - match=1 and round==ROUNDS-1 -> RESULT with win flag.
  - match=1 otherwise -> NEXT.
  - match=0 -> MISS.
- NEXT: round <= round+1 (never wraps, since NEXT is unreachable at the last round); -> SHOW.
- MISS:
  - If lives_left==1: lives_left <= 0, -> RESULT with lose flag.
  - Else: lives_left <= lives_left-1, -> SHOW with round unchanged (retry the same round).
- RESULT:
  - Outputs: E4=1, SEL=1; win or lose =1.
  - round and lives_left hold.
  - press -> IDLE.
- Inputs ignored outside their states: end_FPGA outside SHOW, end_User outside INPUT, match outside CHECK, press outside IDLE/RESULT.
- Latency: the press edge is seen on the cycle enter rises; the state changes on the next edge.

Test Plan:
- Params ROUNDS=4, LIVES=2, TIMEOUT_CYCLES=10 for all scenarios.
- Reset with enter held high, then release -> state_dbg=0, R1=R2=1, lives_left=2, no SETUP until enter goes 0 then 1.
- Full win: 4 rounds, each with end_FPGA, end_User, match=1 -> round steps 0,1,2,3; RESULT with win=1, SEL=1, E4=1, round=3.
- Timeout: no end_User -> MISS exactly 10 cycles after entering INPUT; lives_left 2->1; SHOW again with the same round.
- Second mismatch: match=0 in CHECK with lives_left=1 -> lose=1, lives_left=0. A following press -> IDLE, round=0, lives_left=2.
- Simultaneous end_User on cycle timer=9 -> CHECK, not MISS.
- Reset asserted in INPUT at round 2 -> next edge IDLE, timer=0, round=0; end_FPGA/match pulses in IDLE cause no transition.
